// File: rtl/receptor_serie_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding and bit-order codes.
package receptor_serie_pkg;
  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    DATOS    = 3'd1,
    PAR      = 3'd2,
    PARADA   = 3'd3,
    RECUPERA = 3'd4
  } estado_t;

  localparam logic DIR_IZQ = 1'b0;  // MSB first, shift left
  localparam logic DIR_DER = 1'b1;  // LSB first, shift right
endpackage

// File: rtl/receptor_serie_if.sv
// Serial line in, assembled word and status out. The transmitter/bench side is master.
interface receptor_serie_if #(parameter int ANCHO = 4);
  logic             enb;
  logic             dir;
  logic             s_in;
  logic [ANCHO-1:0] q;
  logic             valido;
  logic             err_par;
  logic             err_trama;
  logic             ocupado;

  modport master (output enb, dir, s_in,
                  input  q, valido, err_par, err_trama, ocupado);
  modport slave  (input  enb, dir, s_in,
                  output q, valido, err_par, err_trama, ocupado);
endinterface

// File: rtl/receptor_serie_desplazador_entrada.sv
// ANCHO-bit input shift register; direction picks which end the new bit enters.
module desplazador_entrada
  import receptor_serie_pkg::*;
#(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             dir,
  input  logic             d,
  output logic [ANCHO-1:0] sh
);
  always_ff @(posedge clk) begin
    if (!rst_n)
      sh <= '0;
    else if (enb)
      sh <= (dir == DIR_DER) ? {d, sh[ANCHO-1:1]} : {sh[ANCHO-2:0], d};
  end
endmodule

// File: rtl/receptor_serie.sv
// Serial-to-parallel receiver: start, ANCHO data bits, optional even parity, stop.
// enb is the bit strobe; status pulses last exactly one clk.
module receptor_serie
  import receptor_serie_pkg::*;
#(
  parameter int ANCHO   = 4,
  parameter bit PARIDAD = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  receptor_serie_if.slave bus
);
  localparam int            CW  = $clog2(ANCHO);
  localparam logic [CW-1:0] ULT = CW'(ANCHO - 1);

  estado_t          est;
  logic [CW-1:0]    cnt;
  logic             dir_l;
  logic             p;
  logic [ANCHO-1:0] sh;
  logic [ANCHO-1:0] q_r;
  logic             valido_r, err_par_r, err_trama_r;
  logic             desplaza;

  // Only data bits enter the shift register; dir is the value latched at the start bit.
  assign desplaza = bus.enb && (est == DATOS);

  desplazador_entrada #(.ANCHO(ANCHO)) u_desp (
    .clk   (clk),
    .rst_n (rst_n),
    .enb   (desplaza),
    .dir   (dir_l),
    .d     (bus.s_in),
    .sh    (sh)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      est         <= ESPERA;
      cnt         <= '0;
      dir_l       <= DIR_IZQ;
      p           <= 1'b0;
      q_r         <= '0;
      valido_r    <= 1'b0;
      err_par_r   <= 1'b0;
      err_trama_r <= 1'b0;
    end else begin
      // Pulses drop on every edge, strobe or not.
      valido_r    <= 1'b0;
      err_par_r   <= 1'b0;
      err_trama_r <= 1'b0;
      if (bus.enb) begin
        case (est)
          ESPERA: if (!bus.s_in) begin
            est   <= DATOS;
            dir_l <= bus.dir;
            cnt   <= '0;
          end
          DATOS: begin
            cnt <= cnt + 1'b1;
            if (cnt == ULT) est <= PARIDAD ? PAR : PARADA;
          end
          PAR: begin
            p   <= bus.s_in;
            est <= PARADA;
          end
          PARADA: if (bus.s_in) begin
            q_r       <= sh;
            valido_r  <= 1'b1;
            err_par_r <= PARIDAD && ((^sh) ^ p);
            est       <= ESPERA;
          end else begin
            err_trama_r <= 1'b1;
            est         <= RECUPERA;
          end
          // A line stuck low after a bad stop must go idle before a new start counts.
          RECUPERA: if (bus.s_in) est <= ESPERA;
          default:  est <= ESPERA;
        endcase
      end
    end
  end

  assign bus.q         = q_r;
  assign bus.valido    = valido_r;
  assign bus.err_par   = err_par_r;
  assign bus.err_trama = err_trama_r;
  assign bus.ocupado   = (est != ESPERA);
endmodule

// File: tb/tb_receptor_serie.sv
// Bench for receptor_serie: one DUT without parity, one with; frame table plus corner sequences.
module tb_receptor_serie;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  receptor_serie_if #(.ANCHO(4)) b0 ();
  receptor_serie_if #(.ANCHO(4)) b1 ();

  receptor_serie #(.ANCHO(4), .PARIDAD(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  receptor_serie #(.ANCHO(4), .PARIDAD(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  typedef struct packed {
    logic [3:0] q;
    logic       ep;
    logic       et;
  } exp_t;

  typedef struct {
    bit         sel;
    bit         d;
    int         n;
    logic [7:0] bits;
    logic [3:0] q;
    bit         ep;
    bit         et;
  } vec_t;

  exp_t sb[2][$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Any valido/err_trama must match the oldest expected result for that DUT.
  task automatic watch(int w, logic v, logic ep, logic et, logic [3:0] q);
    exp_t e;
    if (v || et) begin
      if (sb[w].size() == 0) begin
        chk($sformatf("unexpected_out%0d", w), {6'd0, v, et}, 8'd0);
      end else begin
        e = sb[w].pop_front();
        chk($sformatf("q%0d", w),      {4'd0, q}, {4'd0, e.q});
        chk($sformatf("valido%0d", w), {7'd0, v}, {7'd0, ~e.et});
        chk($sformatf("errpar%0d", w), {7'd0, ep}, {7'd0, e.ep});
        chk($sformatf("errtrama%0d", w), {7'd0, et}, {7'd0, e.et});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    watch(0, b0.valido, b0.err_par, b0.err_trama, b0.q);
    watch(1, b1.valido, b1.err_par, b1.err_trama, b1.q);
  endtask

  task automatic drive(bit sel, bit e, bit d, bit s);
    b0.enb = 1'b1; b0.dir = 1'b0; b0.s_in = 1'b1;
    b1.enb = 1'b1; b1.dir = 1'b0; b1.s_in = 1'b1;
    if (sel) begin b1.enb = e; b1.dir = d; b1.s_in = s; end
    else     begin b0.enb = e; b0.dir = d; b0.s_in = s; end
  endtask

  // First bit sent is bits[n-1]. alt inserts an enb=0 cycle with a wrong line value after
  // every bit; flip>=0 inverts dir after that many bits have been sent.
  task automatic send_frame(bit sel, bit d, int n, logic [7:0] bits, bit alt, int flip);
    for (int i = n - 1; i >= 0; i--) begin
      drive(sel, 1'b1, (flip >= 0 && (n - 1 - i) >= flip) ? ~d : d, bits[i]);
      tick();
      if (alt) begin
        drive(sel, 1'b0, ~d, ~bits[i]);
        tick();
      end
    end
  endtask

  task automatic push(bit sel, logic [3:0] q, bit ep, bit et);
    exp_t e;
    e.q = q; e.ep = ep; e.et = et;
    sb[sel].push_back(e);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 6, 8'b0001_0111, 4'b1011, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 6, 8'b0001_0111, 4'b1101, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 7, 8'b0010_1101, 4'b1011, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 7, 8'b0010_1111, 4'b1011, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 6, 8'b0000_1101, 4'b0110, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 7, 8'b0011_0001, 4'b0011, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 7, 8'b0100_0011, 4'b1000, 1'b0, 1'b0};

    drive(1'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_q0",      {4'd0, b0.q}, 8'd0);
    chk("rst_valido0", {7'd0, b0.valido}, 8'd0);
    chk("rst_errs0",   {6'd0, b0.err_par, b0.err_trama}, 8'd0);
    chk("rst_ocup0",   {7'd0, b0.ocupado}, 8'd0);
    chk("rst_q1",      {4'd0, b1.q}, 8'd0);
    chk("rst_ocup1",   {7'd0, b1.ocupado}, 8'd0);
    rst_n = 1'b1;
    tick();

    // Frame table, back-to-back on each DUT.
    for (int k = 0; k < 7; k++) begin
      push(tbl[k].sel, tbl[k].q, tbl[k].ep, tbl[k].et);
      send_frame(tbl[k].sel, tbl[k].d, tbl[k].n, tbl[k].bits, 1'b0, -1);
      chk($sformatf("drain_v%0d", k), 8'(sb[tbl[k].sel].size()), 8'd0);
    end

    // dir changed after two data bits: frame keeps the latched LSB-first order.
    push(1'b0, 4'b1101, 1'b0, 1'b0);
    send_frame(1'b0, 1'b1, 6, 8'b0001_0111, 1'b0, 3);
    chk("drain_flip", 8'(sb[0].size()), 8'd0);

    // Strobe on every other cycle; valido must still be a single clk.
    push(1'b0, 4'b1011, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 6, 8'b0001_0111, 1'b1, -1);
    chk("drain_alt", 8'(sb[0].size()), 8'd0);
    chk("alt_valido_low", {7'd0, b0.valido}, 8'd0);
    chk("alt_q_hold", {4'd0, b0.q}, 8'h0b);

    // Bad stop bit: q kept, line low is not a new start, then idle recovers.
    push(1'b0, 4'b1011, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 6, 8'b0001_1110, 1'b0, -1);
    chk("drain_trama", 8'(sb[0].size()), 8'd0);
    chk("trama_ocup", {7'd0, b0.ocupado}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk($sformatf("recupera_ocup%0d", i), {7'd0, b0.ocupado}, 8'd1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("recupera_idle", {7'd0, b0.ocupado}, 8'd0);
    chk("recupera_q", {4'd0, b0.q}, 8'h0b);

    // Reset mid-frame, then a clean frame.
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1); tick();
    chk("mid_ocup", {7'd0, b0.ocupado}, 8'd1);
    rst_n = 1'b0;
    tick();
    chk("mrst_q0",    {4'd0, b0.q}, 8'd0);
    chk("mrst_puls0", {5'd0, b0.valido, b0.err_par, b0.err_trama}, 8'd0);
    chk("mrst_ocup0", {7'd0, b0.ocupado}, 8'd0);
    chk("mrst_q1",    {4'd0, b1.q}, 8'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    push(1'b0, 4'b0110, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 6, 8'b0000_1101, 1'b0, -1);
    chk("drain_post_rst", 8'(sb[0].size()), 8'd0);

    drive(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("final_q0", {4'd0, b0.q}, 8'h06);
    chk("final_sb", 8'(sb[0].size() + sb[1].size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
